core_input_loader: RTL and testbench
====================================

Name: core_input_loader

Overview:
- Upstream feeder for the core input controller.
- Accepts a single-word valid/ready stream and assembles one ROWS-wide activation vector plus one ROWS-wide weight vector.
- Presents both vectors, registered, on flat buses that map onto the controller's per-row a/w input ports, with a one-cycle write strobe.
- Tracks occupancy of the downstream skew buffers through a write/read credit counter, so it never overfills them.

Parameters:
- ROWS, 8, number of array rows; also words per vector.
- INWIDTH, 8, bits per activation/weight word.
- DEPTH, 16, downstream buffer depth in vectors; the credit limit.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- s_valid  in  1  stream word valid.
- s_ready  out  1  stream word accepted when s_valid && s_ready.
- s_data  in  INWIDTH  stream word.
- clear  in  1  synchronous abort of a partially assembled vector pair.
- read  in  1  downstream has consumed one vector from its buffers.
- write  out  1  one-cycle strobe; a_vec/w_vec valid this cycle.
- a_vec  out  ROWS*INWIDTH  activation vector; row r at bits [r*INWIDTH +: INWIDTH].
- w_vec  out  ROWS*INWIDTH  weight vector; same row packing.
- occupancy  out  clog2(DEPTH+1)  vectors written but not yet read.
- underflow_err  out  1  sticky; set on read while occupancy==0.

Behaviour:
- Clock/reset: one clock. Reset is asynchronous and active-low.
- Reset values:
  - state=LOAD_A, idx=0, s_ready=1, write=0.
  - a_vec=0, w_vec=0, occupancy=0, underflow_err=0.
  - Shadow registers cleared.
- Stream order per vector pair: ROWS activation words (row 0 first), then ROWS weight words (row 0 first).
- FSM states LOAD_A, LOAD_W, ISSUE:
  - LOAD_A: s_ready=1. On accept, a_shadow[idx]<=s_data and idx++. On the ROWS-th accept, idx<=0 and go to LOAD_W.
  - LOAD_W: s_ready=1. Same, into w_shadow. On the ROWS-th accept, go to ISSUE.
  - ISSUE: s_ready=0. If occupancy<DEPTH, at the edge: a_vec<=a_shadow, w_vec<=w_shadow, write<=1 for exactly one cycle, go to LOAD_A. Otherwise stall in ISSUE with write=0.
- Registered outputs: s_ready is decoded from the registered state (no combinational path from s_valid). write is a registered pulse.
- Output stability: a_vec/w_vec hold their value from the write cycle until the next write.
- Throughput: at best 2*ROWS+1 cycles per vector pair. Latency from the last weight word accepted (edge t) to write high is one cycle: ISSUE during t+1, write high t+2.
- Loading overlap: shadow registers are separate from the output registers, so loading of the next pair starts the cycle write is high.
- Occupancy counter:
  - write only: +1. read only (occupancy>0): -1. Both in the same cycle: unchanged. Never exceeds DEPTH.
  - The ISSUE space check uses the registered occupancy. A read in the same cycle does not free space until the next cycle.
- Underflow:
  - read with occupancy==0 and no write that cycle: occupancy stays 0; underflow_err<=1 until reset.
  - read with occupancy==0 and write the same cycle: occupancy stays 0, no error.
- clear:
  - Forces state=LOAD_A, idx=0 next cycle. Any word presented that cycle is not accepted.
  - Does not affect occupancy, a_vec, w_vec or underflow_err.
  - clear in ISSUE suppresses the pending write. It has priority over the issue.
- Reset mid-operation: all state returns to reset values immediately. A partial vector is discarded. write deasserts asynchronously.

Test Plan:
- Basic load: stream 1..8 then 0x11..0x18, s_valid held high, no backpressure -> write high once, 2 cycles after the 16th accept; a_vec[7:0]=1, a_vec[63:56]=8, w_vec[7:0]=0x11; occupancy=1.
- Credit stall: DEPTH=2, never read, stream 3 full pairs -> 2 writes; occupancy=2. Third pair waits in ISSUE with s_ready=0. Then pulse read once -> write fires the cycle after occupancy reads 1; occupancy back to 2.
- Simultaneous read/write: occupancy=1, read asserted in the write cycle -> occupancy stays 1.
- Underflow: read with occupancy=0 -> underflow_err=1 and stays set; occupancy=0.
- clear mid-load: accept 5 activation words, assert clear, then a full fresh pair 0xA0.. -> a_vec row0=0xA0; only one write; the prior 5 words are absent.
- Async reset mid-ISSUE: drop rstn between clock edges -> write, a_vec, occupancy are 0 immediately. After release, s_ready=1 and the first accepted word lands in row 0.

Source files
------------

// File: rtl/core_input_loader.sv
`timescale 1ns/1ps
// core_input_loader
// Upstream feeder for the core input controller. Collects ROWS activation
// words and then ROWS weight words from a single-word valid/ready stream,
// then presents both vectors together on registered flat buses with a
// one-cycle write strobe. A credit counter tracks how many vectors sit in
// the downstream skew buffers, so the loader never overfills them.
//
// State table:
//   LOAD_A | accepting activation words into a_shadow, row 0 first
//   LOAD_W | accepting weight words into w_shadow, row 0 first
//   ISSUE  | pair complete; waiting for buffer space, then pulses write
//
// Ports:
//   clk, rstn        clock, async active-low reset
//   s_valid/s_ready  stream handshake; s_data is the stream word
//   clear            synchronous abort of a partially assembled pair
//   read             downstream consumed one vector
//   write            one-cycle strobe; a_vec/w_vec are valid this cycle
//   a_vec, w_vec     row r at bits [r*INWIDTH +: INWIDTH]
//   occupancy        vectors written but not yet read
//   underflow_err    sticky; read seen while occupancy was 0
module core_input_loader #(
    parameter int ROWS    = 8,
    parameter int INWIDTH = 8,
    parameter int DEPTH   = 16,
    localparam int OW     = $clog2(DEPTH + 1),
    localparam int IW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [INWIDTH-1:0]      s_data,
    input  logic                    clear,
    input  logic                    read,
    output logic                    write,
    output logic [ROWS*INWIDTH-1:0] a_vec,
    output logic [ROWS*INWIDTH-1:0] w_vec,
    output logic [OW-1:0]           occupancy,
    output logic                    underflow_err
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_W = 2'd1,
        ISSUE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 load_a, load_w, issue;
    logic                 accept, last_word;
    logic [INWIDTH-1:0]   a_shadow [ROWS];
    logic [INWIDTH-1:0]   w_shadow [ROWS];
    logic [ROWS*INWIDTH-1:0] a_pack, w_pack;

    // Ready comes purely from the registered state, so there is no
    // combinational path from s_valid back to s_ready.
    assign s_ready   = (state_q != ISSUE);
    assign accept    = s_valid && s_ready && !clear;
    assign last_word = (idx_q == IW'(ROWS - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load_a  = 1'b0;
        load_w  = 1'b0;
        issue   = 1'b0;
        if (clear) begin
            // Abort wins over everything, including a pending issue.
            state_d = LOAD_A;
            idx_d   = '0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (accept) begin
                        load_a = 1'b1;
                        if (last_word) begin
                            idx_d   = '0;
                            state_d = LOAD_W;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
                LOAD_W: begin
                    if (accept) begin
                        load_w = 1'b1;
                        if (last_word) begin
                            idx_d   = '0;
                            state_d = ISSUE;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
                ISSUE: begin
                    // Space check uses the registered count; a read in this
                    // same cycle only frees space from the next cycle on.
                    if (occupancy < OW'(DEPTH)) begin
                        issue   = 1'b1;
                        state_d = LOAD_A;
                    end
                end
                default: begin
                    state_d = LOAD_A;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= LOAD_A;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < ROWS; r++) begin
                a_shadow[r] <= '0;
                w_shadow[r] <= '0;
            end
        end else begin
            if (load_a) a_shadow[idx_q] <= s_data;
            if (load_w) w_shadow[idx_q] <= s_data;
        end
    end

    always_comb begin
        a_pack = '0;
        w_pack = '0;
        for (int r = 0; r < ROWS; r++) begin
            a_pack[r*INWIDTH +: INWIDTH] = a_shadow[r];
            w_pack[r*INWIDTH +: INWIDTH] = w_shadow[r];
        end
    end

    // Output registers are separate from the shadows, so the next pair
    // starts loading in the same cycle write is high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            write <= 1'b0;
            a_vec <= '0;
            w_vec <= '0;
        end else begin
            write <= issue;
            if (issue) begin
                a_vec <= a_pack;
                w_vec <= w_pack;
            end
        end
    end

    // Credit counter follows the write strobe itself. A read that meets a
    // write in the same cycle cancels out, even at zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occupancy     <= '0;
            underflow_err <= 1'b0;
        end else begin
            case ({write, read})
                2'b10: begin
                    if (occupancy != OW'(DEPTH)) occupancy <= occupancy + OW'(1);
                end
                2'b01: begin
                    if (occupancy != '0) occupancy <= occupancy - OW'(1);
                    else                 underflow_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_input_loader.sv
`timescale 1ns/1ps
module tb_core_input_loader;

    localparam int ROWS    = 8;
    localparam int INWIDTH = 8;
    localparam int DEPTH   = 2;
    localparam int VW      = ROWS * INWIDTH;
    localparam int OW      = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [INWIDTH-1:0] s_data = '0;
    logic              clear = 1'b0;
    logic              read = 1'b0;
    logic              write;
    logic [VW-1:0]     a_vec, w_vec;
    logic [OW-1:0]     occupancy;
    logic              underflow_err;

    core_input_loader #(.ROWS(ROWS), .INWIDTH(INWIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .clear(clear), .read(read),
        .write(write), .a_vec(a_vec), .w_vec(w_vec),
        .occupancy(occupancy), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a pair is simply 2*ROWS words in arrival order;
    // m_pos counts how many of them have arrived.
    int               m_pos;
    bit               m_full;
    int               m_occ;
    bit               m_err;
    bit               m_write;
    logic [INWIDTH-1:0] m_a [ROWS];
    logic [INWIDTH-1:0] m_w [ROWS];
    logic [VW-1:0]    m_avec, m_wvec;
    int               writes_seen;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_full = 0; m_occ = 0; m_err = 0; m_write = 0;
        m_avec = '0; m_wvec = '0;
        for (int r = 0; r < ROWS; r++) begin
            m_a[r] = '0;
            m_w[r] = '0;
        end
    endtask

    // One clock: capture inputs, take the edge, advance model, compare.
    task automatic cyc();
        bit v, c, rd, acc, nw;
        logic [INWIDTH-1:0] d;
        v = s_valid; c = clear; rd = read; d = s_data;
        @(posedge clk);
        #1;
        acc = v && !m_full && !c;
        nw  = m_full && (m_occ < DEPTH) && !c;
        if (m_write && !rd) begin
            if (m_occ < DEPTH) m_occ++;
        end else if (rd && !m_write) begin
            if (m_occ > 0) m_occ--;
            else m_err = 1;
        end
        if (c) begin
            m_pos = 0; m_full = 0;
        end else if (nw) begin
            for (int r = 0; r < ROWS; r++) begin
                m_avec[r*INWIDTH +: INWIDTH] = m_a[r];
                m_wvec[r*INWIDTH +: INWIDTH] = m_w[r];
            end
            m_pos = 0; m_full = 0;
        end else if (acc) begin
            if (m_pos < ROWS) m_a[m_pos] = d;
            else              m_w[m_pos - ROWS] = d;
            m_pos++;
            if (m_pos == 2 * ROWS) m_full = 1;
        end
        m_write = nw;
        if (nw) writes_seen++;
        chk("s_ready", VW'(s_ready), VW'(!m_full));
        chk("write", VW'(write), VW'(m_write));
        chk("occupancy", VW'(occupancy), VW'(m_occ));
        chk("underflow_err", VW'(underflow_err), VW'(m_err));
        chk("a_vec", a_vec, m_avec);
        chk("w_vec", w_vec, m_wvec);
    endtask

    task automatic send(input logic [INWIDTH-1:0] word);
        s_valid = 1'b1;
        s_data  = word;
        cyc();
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) cyc();
    endtask

    initial begin
        int w0;
        writes_seen = 0;
        model_reset();

        // Reset values
        #12;
        chk("rst_s_ready", VW'(s_ready), VW'(1));
        chk("rst_write", VW'(write), VW'(0));
        chk("rst_occupancy", VW'(occupancy), VW'(0));
        chk("rst_underflow", VW'(underflow_err), VW'(0));
        chk("rst_a_vec", a_vec, '0);
        chk("rst_w_vec", w_vec, '0);
        @(negedge clk);
        rstn = 1'b1;

        // Basic load
        for (int i = 0; i < ROWS; i++) send(INWIDTH'(i + 1));
        for (int i = 0; i < ROWS; i++) send(INWIDTH'(8'h11 + i));
        idle(1);
        chk("basic_write", VW'(write), VW'(1));
        chk("basic_a_row0", VW'(a_vec[7:0]), VW'(8'h01));
        chk("basic_a_row7", VW'(a_vec[63:56]), VW'(8'h08));
        chk("basic_w_row0", VW'(w_vec[7:0]), VW'(8'h11));
        idle(1);
        chk("basic_occ", VW'(occupancy), VW'(1));

        // Credit stall
        for (int i = 0; i < 2 * ROWS; i++) send(INWIDTH'($urandom));
        idle(2);
        chk("credit_occ_full", VW'(occupancy), VW'(2));
        for (int i = 0; i < 2 * ROWS; i++) send(INWIDTH'($urandom));
        idle(4);
        chk("credit_stall_ready", VW'(s_ready), VW'(0));
        chk("credit_stall_write", VW'(write), VW'(0));
        read = 1'b1;
        cyc();
        read = 1'b0;
        chk("credit_occ_after_read", VW'(occupancy), VW'(1));
        cyc();
        chk("credit_release_write", VW'(write), VW'(1));
        // Read during the write cycle: count unchanged
        read = 1'b1;
        cyc();
        read = 1'b0;
        chk("simul_rw_occ", VW'(occupancy), VW'(1));

        // Underflow
        read = 1'b1;
        cyc();
        cyc();
        read = 1'b0;
        idle(3);
        chk("underflow_err", VW'(underflow_err), VW'(1));
        chk("underflow_occ", VW'(occupancy), VW'(0));

        // clear mid-load
        for (int i = 0; i < 5; i++) send(INWIDTH'(8'h30 + i));
        s_valid = 1'b1;
        s_data  = 8'hEE;
        clear   = 1'b1;
        cyc();
        clear = 1'b0;
        w0 = writes_seen;
        for (int i = 0; i < 2 * ROWS; i++) send(INWIDTH'(8'hA0 + i));
        idle(3);
        chk("clear_one_write", VW'(writes_seen - w0), VW'(1));
        chk("clear_a_row0", VW'(a_vec[7:0]), VW'(8'hA0));
        chk("clear_a_row7", VW'(a_vec[63:56]), VW'(8'hA7));
        chk("clear_w_row0", VW'(w_vec[7:0]), VW'(8'hA8));

        // Async reset while write is high
        for (int i = 0; i < 2 * ROWS; i++) send(INWIDTH'($urandom_range(1, 255)));
        idle(1);
        chk("pre_reset_write", VW'(write), VW'(1));
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_write", VW'(write), VW'(0));
        chk("arst_a_vec", a_vec, '0);
        chk("arst_occ", VW'(occupancy), VW'(0));
        chk("arst_s_ready", VW'(s_ready), VW'(1));
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        send(8'h5A);
        for (int i = 1; i < 2 * ROWS; i++) send(INWIDTH'(8'h60 + i));
        idle(2);
        chk("post_reset_row0", VW'(a_vec[7:0]), VW'(8'h5A));

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            s_valid = ($urandom_range(0, 9) < 7);
            s_data  = INWIDTH'($urandom);
            read    = ($urandom_range(0, 9) < 2);
            clear   = ($urandom_range(0, 49) == 0);
            cyc();
        end
        read  = 1'b0;
        clear = 1'b0;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
